pipeline_hazard_ctrl: RTL and testbench

- Parametrised hazard and stall controller for the in-order RISC-V pipeline. Sits beside the datapath and drives PC enable, IBus read control, DBus translator enable, and per-stage pipeline-register enable/clear vectors.
- Generalises the fixed 5-stage controller to any number of post-decode stages and a configurable branch-resolve stage and penalty.
- Adds x0 filtering, IBus wait stalls, correct freeze of the penalty counter during DBus waits, and a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 10 +
 rtl/hazard_match.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard/stall controller.
package hazard_pkg;

  localparam int STG_IF2 = 0;
  localparam int STG_D   = 1;
  localparam int STG_E   = 2;

  localparam int PEN_W = 3;

endpackage

// File: rtl/hazard_match.sv
// Load-use compare of one post-decode stage's rd against the decode sources.
module hazard_match #(
  parameter int ADDR_W    = 5,
  parameter bit IGNORE_X0 = 1'b1
) (
  input  logic              i_RS1Valid,
  input  logic [ADDR_W-1:0] i_RS1Addr,
  input  logic              i_RS2Valid,
  input  logic [ADDR_W-1:0] i_RS2Addr,
  input  logic [ADDR_W-1:0] i_RDAddr,
  input  logic              i_IsMemRead,
  output logic              o_Match
);

  logic rs1Hit;
  logic rs2Hit;

  always_comb begin
    rs1Hit = i_RS1Valid && (i_RS1Addr == i_RDAddr);
    rs2Hit = i_RS2Valid && (i_RS2Addr == i_RDAddr);
    // x0 is hard-wired zero, so a read of it never depends on a load
    if (IGNORE_X0) begin
      if (i_RS1Addr == '0) rs1Hit = 1'b0;
      if (i_RS2Addr == '0) rs2Hit = 1'b0;
    end
    o_Match = i_IsMemRead && (rs1Hit || rs2Hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller: load-use, bus waits, branch penalty and a
// saturating stall-cycle counter for the in-order pipeline.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int HAZ_STAGES     = 3,
  parameter int ADDR_W         = 5,
  parameter int BR_STAGE       = 3,
  parameter int BRANCH_PENALTY = 2,
  parameter bit IGNORE_X0      = 1'b1,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_n,
  input  logic                         i_RS1Valid_D,
  input  logic [ADDR_W-1:0]            i_RS1Addr_D,
  input  logic                         i_RS2Valid_D,
  input  logic [ADDR_W-1:0]            i_RS2Addr_D,
  input  logic [HAZ_STAGES*ADDR_W-1:0] i_RDAddr,
  input  logic [HAZ_STAGES-1:0]        i_IsMemRead,
  input  logic                         i_IBusWaitReq_F,
  input  logic                         i_DBusWaitReq_M,
  input  logic                         i_TakeBranch,
  input  logic                         i_StallCntClr,
  output logic                         o_PcEn,
  output logic                         o_IBusRdEn,
  output logic                         o_IBusOZero,
  output logic                         o_DBusTranslatorEn,
  output logic [HAZ_STAGES+1:0]        o_RegEn,
  output logic [HAZ_STAGES+1:0]        o_RegClr,
  output logic                         o_Busy,
  output logic [STALL_CNT_W-1:0]       o_StallCount
);

  localparam int NUM_REGS = HAZ_STAGES + 2;
  localparam logic [NUM_REGS-1:0] BR_CLR_MASK =
    NUM_REGS'((64'd1 << (BR_STAGE + 1)) - 64'd1);
  localparam logic [PEN_W-1:0] PEN_LOAD = PEN_W'(BRANCH_PENALTY);

  logic                   r_DBusWait;
  logic [PEN_W-1:0]       r_Penalty;
  logic [STALL_CNT_W-1:0] r_StallCnt;
  logic [PEN_W-1:0]       penNext;
  logic [STALL_CNT_W-1:0] cntNext;
  logic [HAZ_STAGES-1:0]  hzVec;
  logic                   hz;

  for (genvar k = 0; k < HAZ_STAGES; k++) begin : g_match
    hazard_match #(
      .ADDR_W   (ADDR_W),
      .IGNORE_X0(IGNORE_X0)
    ) u_match (
      .i_RS1Valid (i_RS1Valid_D),
      .i_RS1Addr  (i_RS1Addr_D),
      .i_RS2Valid (i_RS2Valid_D),
      .i_RS2Addr  (i_RS2Addr_D),
      .i_RDAddr   (i_RDAddr[k*ADDR_W +: ADDR_W]),
      .i_IsMemRead(i_IsMemRead[k]),
      .o_Match    (hzVec[k])
    );
  end

  assign hz = |hzVec;

  always_comb begin
    o_PcEn             = 1'b1;
    o_IBusRdEn         = 1'b1;
    o_IBusOZero        = 1'b0;
    o_DBusTranslatorEn = 1'b1;
    o_RegEn            = '1;
    o_RegClr           = '0;
    // Reset held low forces defaults regardless of the hazard inputs
    if (i_Rst_n) begin
      if (r_DBusWait) begin
        o_PcEn             = 1'b0;
        o_IBusRdEn         = 1'b0;
        o_DBusTranslatorEn = 1'b0;
        o_RegEn            = '0;
      end else begin
        if (i_TakeBranch) begin
          o_RegClr = BR_CLR_MASK;
        end else if (hz) begin
          o_PcEn           = 1'b0;
          o_IBusRdEn       = 1'b0;
          o_RegEn[STG_IF2] = 1'b0;
          o_RegEn[STG_D]   = 1'b0;
          o_RegClr[STG_E]  = 1'b1;
        end else if (i_IBusWaitReq_F) begin
          o_PcEn           = 1'b0;
          o_RegEn[STG_IF2] = 1'b0;
          o_RegClr[STG_D]  = 1'b1;
        end
        if (r_Penalty != '0) begin
          o_RegEn[STG_E] = 1'b0;
          o_IBusOZero    = 1'b1;
          if (r_Penalty > PEN_W'(1)) begin
            o_RegEn[STG_IF2] = 1'b0;
            o_RegEn[STG_D]   = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    penNext = r_Penalty;
    if (!r_DBusWait) begin
      if (i_TakeBranch)           penNext = PEN_LOAD;
      else if (r_Penalty != '0)   penNext = r_Penalty - PEN_W'(1);
    end
    cntNext = r_StallCnt;
    if (i_StallCntClr)                          cntNext = '0;
    else if (!o_PcEn && (r_StallCnt != '1))     cntNext = r_StallCnt + STALL_CNT_W'(1);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_DBusWait <= 1'b0;
      r_Penalty  <= '0;
      r_StallCnt <= '0;
    end else begin
      r_DBusWait <= i_DBusWaitReq_M;
      r_Penalty  <= penNext;
      r_StallCnt <= cntNext;
    end
  end

  assign o_Busy       = (r_Penalty != '0);
  assign o_StallCount = r_StallCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl against a
// cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int HS  = 3;
  localparam int AW  = 5;
  localparam int BRS = 3;
  localparam int BP  = 2;
  localparam int SW  = 6;
  localparam int NR  = HS + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rs1v, rs2v;
  logic [AW-1:0] rs1a, rs2a;
  logic [HS*AW-1:0] rdAddr;
  logic [HS-1:0] isMem;
  logic          ibw, dbw, br, clr;

  logic          o_PcEn, o_IBusRdEn, o_IBusOZero, o_DBusTranslatorEn, o_Busy;
  logic [NR-1:0] o_RegEn, o_RegClr;
  logic [SW-1:0] o_StallCount;

  int nCmp = 0;
  int nErr = 0;

  // model state
  int mPen, mCnt;
  bit mDbw;
  logic ePcEn, eIRd, eOZ, eDTr, eBusy;
  logic [NR-1:0] eRegEn, eRegClr;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .HAZ_STAGES    (HS),
    .ADDR_W        (AW),
    .BR_STAGE      (BRS),
    .BRANCH_PENALTY(BP),
    .IGNORE_X0     (1'b1),
    .STALL_CNT_W   (SW)
  ) dut (
    .i_Clk             (clk),
    .i_Rst_n           (rst_n),
    .i_RS1Valid_D      (rs1v),
    .i_RS1Addr_D       (rs1a),
    .i_RS2Valid_D      (rs2v),
    .i_RS2Addr_D       (rs2a),
    .i_RDAddr          (rdAddr),
    .i_IsMemRead       (isMem),
    .i_IBusWaitReq_F   (ibw),
    .i_DBusWaitReq_M   (dbw),
    .i_TakeBranch      (br),
    .i_StallCntClr     (clr),
    .o_PcEn            (o_PcEn),
    .o_IBusRdEn        (o_IBusRdEn),
    .o_IBusOZero       (o_IBusOZero),
    .o_DBusTranslatorEn(o_DBusTranslatorEn),
    .o_RegEn           (o_RegEn),
    .o_RegClr          (o_RegClr),
    .o_Busy            (o_Busy),
    .o_StallCount      (o_StallCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1v = 0; rs2v = 0; rs1a = '0; rs2a = '0; rdAddr = '0; isMem = '0;
    ibw = 0; dbw = 0; br = 0; clr = 0;
  endtask

  function automatic bit srcHits(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] rd);
    return v && a == rd && a != 0;
  endfunction

  // Reference: compute expected outputs from the current model state and inputs
  task automatic modelOut();
    bit hazard = 0;
    for (int k = 0; k < HS; k++)
      if (isMem[k] && (srcHits(rs1v, rs1a, rdAddr[k*AW +: AW]) ||
                       srcHits(rs2v, rs2a, rdAddr[k*AW +: AW])))
        hazard = 1;
    ePcEn = 1; eIRd = 1; eOZ = 0; eDTr = 1; eRegEn = '1; eRegClr = '0;
    eBusy = (mPen != 0);
    if (rst_n) begin
      if (mDbw) begin
        ePcEn = 0; eIRd = 0; eDTr = 0; eRegEn = '0;
      end else begin
        if (br) begin
          for (int i = 0; i <= BRS; i++) eRegClr[i] = 1'b1;
        end else if (hazard) begin
          ePcEn = 0; eIRd = 0; eRegEn[1:0] = 2'b00; eRegClr[2] = 1'b1;
        end else if (ibw) begin
          ePcEn = 0; eRegEn[0] = 1'b0; eRegClr[1] = 1'b1;
        end
        if (mPen > 0) begin
          eRegEn[2] = 1'b0; eOZ = 1;
          if (mPen > 1) eRegEn[1:0] = 2'b00;
        end
      end
    end
  endtask

  // Called at posedge+1: settle to the negedge and compare everything
  task automatic checkModel(input string tag);
    #4;
    modelOut();
    chk({tag, ".vec"},
        {11'd0, o_PcEn, o_IBusRdEn, o_IBusOZero, o_DBusTranslatorEn, o_Busy, o_RegEn, o_RegClr, o_StallCount},
        {11'd0, ePcEn, eIRd, eOZ, eDTr, eBusy, eRegEn, eRegClr, SW'(mCnt)});
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst_n) begin
      mPen = 0; mDbw = 0; mCnt = 0;
    end else begin
      if (!mDbw) begin
        if (br) mPen = BP;
        else if (mPen > 0) mPen--;
      end
      mDbw = dbw;
      if (clr) mCnt = 0;
      else if (!ePcEn && mCnt < (1 << SW) - 1) mCnt++;
    end
    #1;
  endtask

  task automatic step(input string tag);
    checkModel(tag);
    adv();
  endtask

  initial begin
    idle();
    rst_n = 0;
    mPen = 0; mDbw = 0; mCnt = 0;
    #12 rst_n = 1;
    @(posedge clk); #1;

    // reset state
    checkModel("reset");
    chk("reset.regen", 32'(o_RegEn), 32'h1F);
    chk("reset.cnt", 32'(o_StallCount), 32'h0);
    adv();

    // load-use at E
    isMem = 3'b001; rdAddr[0 +: AW] = 5'd5; rs1v = 1; rs1a = 5'd5;
    checkModel("lu");
    chk("lu.pcen", 32'(o_PcEn), 32'h0);
    chk("lu.regen", 32'(o_RegEn), 32'h1C);
    chk("lu.regclr", 32'(o_RegClr), 32'h04);
    adv();
    idle();
    checkModel("lu.after");
    chk("lu.cnt", 32'(o_StallCount), 32'h1);
    adv();

    // x0 filtered at W
    isMem = 3'b100; rdAddr[2*AW +: AW] = 5'd0; rs2v = 1; rs2a = 5'd0;
    checkModel("x0");
    chk("x0.regen", 32'(o_RegEn), 32'h1F);
    chk("x0.pcen", 32'(o_PcEn), 32'h1);
    adv();
    idle();

    // taken branch and penalty sequence
    br = 1;
    checkModel("br0");
    chk("br0.regclr", 32'(o_RegClr), 32'h0F);
    adv(); br = 0;
    checkModel("br1");
    chk("br1.regen", 32'(o_RegEn), 32'h18);
    chk("br1.ozero", 32'(o_IBusOZero), 32'h1);
    adv();
    checkModel("br2");
    chk("br2.regen", 32'(o_RegEn), 32'h1B);
    adv();
    checkModel("br3");
    chk("br3.busy", 32'(o_Busy), 32'h0);
    adv();

    // data bus wait freezes a penalty of 2
    br = 1; dbw = 1;
    step("dw0");
    br = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dbw = 0;
      checkModel("dwhold");
      chk("dwhold.regen", 32'(o_RegEn), 32'h00);
      chk("dwhold.busy", 32'(o_Busy), 32'h1);
      if (i < 2) dbw = 1;
      adv();
    end
    dbw = 0;
    checkModel("dw.res1");
    chk("dw.res1.regen", 32'(o_RegEn), 32'h18);
    adv();
    checkModel("dw.res2");
    chk("dw.res2.regen", 32'(o_RegEn), 32'h1B);
    adv();
    step("dw.done");

    // branch beats load-use
    br = 1; isMem = 3'b010; rdAddr[AW +: AW] = 5'd7; rs1v = 1; rs1a = 5'd7;
    checkModel("brlu");
    chk("brlu.pcen", 32'(o_PcEn), 32'h1);
    chk("brlu.regclr", 32'(o_RegClr), 32'h0F);
    adv();
    idle();
    repeat (3) step("brlu.drain");

    // stall counter saturation and clear
    isMem = 3'b001; rdAddr[0 +: AW] = 5'd3; rs2v = 1; rs2a = 5'd3;
    repeat (70) step("sat");
    checkModel("sat.end");
    chk("sat.cnt", 32'(o_StallCount), 32'((1 << SW) - 1));
    adv();
    idle(); clr = 1;
    step("clr");
    clr = 0;
    checkModel("clr.after");
    chk("clr.cnt", 32'(o_StallCount), 32'h0);
    adv();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rs1v = 1'($urandom_range(0, 1)); rs1a = AW'($urandom_range(0, 3));
      rs2v = 1'($urandom_range(0, 1)); rs2a = AW'($urandom_range(0, 3));
      for (int k = 0; k < HS; k++) begin
        rdAddr[k*AW +: AW] = AW'($urandom_range(0, 3));
        isMem[k] = ($urandom_range(0, 2) == 0);
      end
      ibw = ($urandom_range(0, 3) == 0);
      dbw = ($urandom_range(0, 5) == 0);
      br  = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 31) == 0);
      step("rnd");
    end
    idle();
    step("rnd.quiet");

    // reset mid-penalty
    br = 1;
    step("rst.br");
    br = 0;
    checkModel("rst.pen");
    chk("rst.busy1", 32'(o_Busy), 32'h1);
    #1 rst_n = 0;
    #1;
    chk("rst.busy0", 32'(o_Busy), 32'h0);
    chk("rst.regen", 32'(o_RegEn), 32'h1F);
    mPen = 0; mDbw = 0; mCnt = 0;
    adv();
    step("rst.low");
    rst_n = 1;
    step("rst.rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
